// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and CTRL/status bit positions for the PWM engine.
package pwm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} pwm_state_t;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_POL     = 2;
    localparam int CTRL_DT_LSB  = 4;
    localparam int CTRL_DT_MSB  = 7;
    localparam int ST_RUN       = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_R         = 2;
    localparam int ST_WR_LSB    = 4;
    localparam int ST_WR_MSB    = 7;
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: holds each phase inactive for the first dt enabled ticks after an edge of r.
module pwm_deadtime (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       clr,
    input  logic       r,
    input  logic [3:0] dt,
    output logic       p_act,
    output logic       n_act
);
    logic       r_q;
    logic [3:0] dt_cnt;
    logic [3:0] base;
    // the edge cycle itself counts as tick zero of the new phase
    assign base  = (r != r_q) ? 4'd0 : dt_cnt;
    assign p_act = r && (base >= dt);
    assign n_act = !r && (base >= dt);
    always_ff @(posedge clk) begin
        r_q    <= rst ? 1'b0 : r;
        dt_cnt <= (rst || clr) ? 4'd0 : ((ena && base < dt) ? base + 4'd1 : base);
    end
endmodule

// File: rtl/pwm_engine.sv
// pwm_engine: double-buffered single-channel PWM with one-shot mode; PWM_DEADTIME_EN adds dead time.
module pwm_engine
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [2:0][WIDTH-1:0] config_regs,
    output logic                  pwm_p,
    output logic                  pwm_n,
    output logic [WIDTH-1:0]      status_regs
);
    pwm_state_t       state;
    logic [WIDTH-1:0] ctrl, period, duty;
    logic [WIDTH-1:0] cnt, per_sh, duty_sh;
    logic [WIDTH-1:0] status_next;
    logic [3:0]       wraps;
    logic             en, oneshot, pol, r, wrap, run, p_act, n_act;
    logic             unused_ctrl;
    assign ctrl        = config_regs[0];
    assign period      = config_regs[1];
    assign duty        = config_regs[2];
    assign unused_ctrl = ^ctrl;
    assign en          = ctrl[CTRL_EN];
    assign oneshot     = ctrl[CTRL_ONESHOT];
    assign pol         = ctrl[CTRL_POL];
    assign r           = cnt < duty_sh;
    assign run         = state == RUN;
    assign wrap        = ena && cnt == per_sh;
`ifdef PWM_DEADTIME_EN
    pwm_deadtime u_deadtime (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .clr  (!run),
        .r    (r),
        .dt   (ctrl[CTRL_DT_MSB:CTRL_DT_LSB]),
        .p_act(p_act),
        .n_act(n_act)
    );
`else
    assign p_act = r;
    assign n_act = !r;
`endif
    always_comb begin
        status_next                       = '0;
        status_next[ST_RUN]               = run;
        status_next[ST_DONE]              = state == DONE;
        status_next[ST_R]                 = r;
        status_next[ST_WR_MSB:ST_WR_LSB]  = wraps;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            per_sh      <= '0;
            duty_sh     <= '0;
            wraps       <= '0;
            pwm_p       <= 1'b0;
            pwm_n       <= 1'b0;
            status_regs <= '0;
        end else begin
            pwm_p       <= (run && p_act) ^ pol;
            pwm_n       <= (run && n_act) ^ pol;
            status_regs <= status_next;
            if (state == IDLE) begin
                if (en) begin
                    state   <= RUN;
                    cnt     <= '0;
                    per_sh  <= period;
                    duty_sh <= duty;
                    wraps   <= '0;
                end
            end else if (run) begin
                // a boundary is still counted when EN drops on the same cycle
                if (wrap) wraps <= (wraps == 4'hf) ? wraps : wraps + 4'd1;
                if (!en) state <= IDLE;
                else if (wrap && oneshot) state <= DONE;
                else if (wrap) begin
                    cnt     <= '0;
                    per_sh  <= period;
                    duty_sh <= duty;
                end else if (ena) cnt <= cnt + 1'b1;
            end else if (!en) state <= IDLE;
        end
    end
endmodule
